// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared arbiter state encoding, owner codes and counter widths
package pcpu_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/arb_sat_cnt.sv
// arb_sat_cnt: 32-bit counter that increments on inc and holds at all-ones
module arb_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 32'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between IF and DM with DM priority and IF anti-starvation
// ARB_PERF_CNT_EN adds saturating conflict/busy performance counters.
module mem_arbiter
  import pcpu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_conflict_cnt,
  output logic [31:0]   perf_busy_cnt
`endif
);
  arb_state_t state;
  logic owner;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic grant_dm;
  // DM wins a conflict unless IF has already waited out STARVE_LIMIT DM grants
  assign grant_dm = dm_req && !(if_req && starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        ARB_IDLE:
          if (if_req || dm_req) begin
            owner      <= grant_dm ? OWN_DM : OWN_IF;
            mem_we     <= grant_dm && dm_we;
            mem_addr   <= grant_dm ? dm_addr : if_addr;
            mem_wdata  <= grant_dm ? dm_wdata : mem_wdata;
            starve_cnt <= (grant_dm && if_req) ? starve_cnt + 1'b1 : '0;
            mem_req    <= 1'b1;
            state      <= ARB_BUSY;
          end
        ARB_BUSY:
          if (mem_ack) begin
            if (owner == OWN_IF) if_rdata <= mem_rdata;
            if (owner == OWN_DM && !mem_we) dm_rdata <= mem_rdata;
            if_ack  <= owner == OWN_IF;
            dm_ack  <= owner == OWN_DM;
            mem_req <= 1'b0;
            state   <= ARB_RESP;
          end
        default: state <= ARB_IDLE;
      endcase
    end
  end
`ifdef ARB_PERF_CNT_EN
  arb_sat_cnt u_conflict (
    .clk(clk), .rst(rst),
    .inc(state == ARB_IDLE && if_req && dm_req),
    .cnt(perf_conflict_cnt)
  );
  arb_sat_cnt u_busy (
    .clk(clk), .rst(rst),
    .inc(mem_req),
    .cnt(perf_busy_cnt)
  );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, starvation and reset with a small memory model
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_ack, dm_req = 1'b0, dm_we = 1'b0, dm_ack;
  logic [31:0] if_addr = '0, if_rdata, dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_cnt, perf_busy_cnt;
`endif
  logic [31:0] mem [0:255];
  int          wcnt = 0;
  int          delay = 0;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );
  // memory acks after `delay` extra cycles of mem_req; writes land on the acking edge
  assign mem_ack   = mem_req && wcnt == delay;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    wcnt <= (rst || !mem_req) ? 0 : wcnt + 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_ack(input string tag, output logic got_dm);
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if_ack || dm_ack) break;
    end
    chk({tag, "_timeout"}, 64'(n < 40), 64'd1);
    got_dm = dm_ack;
  endtask
  initial begin
    logic  d;
    string seq, exp_seq;
    int    rc, last, ack_i, bad;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'h2402_0005;
    mem[17] = 32'h1111_2222;
    mem[8]  = 32'hCAFE_0001;
    // reset values while rst held
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_acks", {if_ack, dm_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    // 1: IF only, single-cycle memory
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_no_ack_early", {if_ack, dm_ack}, 0);
    @(negedge clk);
    chk("t1_if_ack", if_ack, 1);
    chk("t1_dm_ack", dm_ack, 0);
    chk("t1_if_rdata", if_rdata, 32'h2402_0005);
    chk("t1_mem_req_clr", mem_req, 0);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", if_ack, 0);
    // 2: simultaneous DM write and IF read
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    chk("t2_dm_addr", mem_addr, 32'h10);
    chk("t2_dm_we", mem_we, 1);
    chk("t2_dm_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_dm_ack", {if_ack, dm_ack}, 2'b01);
    chk("t2_dm_rdata_kept", dm_rdata, 0);
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chk("t2_idle_gap", {mem_req, if_ack, dm_ack}, 0);
    @(negedge clk);
    chk("t2_if_grant", {mem_req, mem_we}, 2'b10);
    chk("t2_if_addr", mem_addr, 32'h44);
    @(negedge clk);
    chk("t2_if_ack", {if_ack, dm_ack}, 2'b10);
    chk("t2_if_rdata", if_rdata, 32'h1111_2222);
    chk("t2_mem_written", mem[4], 32'hDEAD_BEEF);
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_conflict", perf_conflict_cnt, 1);
    chk("t6_perf_busy", perf_busy_cnt, 2);
`endif
    if_req = 1'b0;
    // 3: IF starvation guard with DM hammering
    do_reset();
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_addr = 32'h100;
    seq = "";
    exp_seq = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      wait_ack("t3", d);
      seq = {seq, d ? "D" : "I"};
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("t3_order%0d", k), 64'(seq[k]), 64'(exp_seq[k]));
    if_req = 1'b0; dm_req = 1'b0;
    // 4: DM read with 5 wait cycles
    do_reset();
    delay = 5;
    dm_req = 1'b1; dm_addr = 32'h20;
    rc = 0; last = -1; ack_i = -1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        rc++; last = i;
        if (mem_addr != 32'h20) bad++;
      end
      if (dm_ack) begin
        ack_i = i;
        break;
      end
    end
    chk("t4_req_cycles", 64'(rc), 64'd6);
    chk("t4_addr_stable", 64'(bad), 64'd0);
    chk("t4_ack_latency", 64'(ack_i), 64'(last + 1));
    chk("t4_dm_rdata", dm_rdata, 32'hCAFE_0001);
    dm_req = 1'b0;
    // 5: reset during BUSY abandons the transaction
    do_reset();
    delay = 5;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("t5_busy", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_req_dropped", mem_req, 0);
    chk("t5_no_ack", {if_ack, dm_ack}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_regrant", mem_req, 1);
    chk("t5_regrant_addr", mem_addr, 32'h40);
    wait_ack("t5", d);
    chk("t5_owner", d, 0);
    chk("t5_if_rdata", if_rdata, 32'h2402_0005);
    if_req = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
